// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour BCD time of day with N independent alarms,
// each with its own ring/snooze state machine and automatic ring timeout.
module multi_alarm_clock #(
    parameter int CLK_DIV      = 10,
    parameter int N_ALARMS     = 4,
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_TIMEOUT = 60,
    localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          H_in1,
    input  logic [3:0]          H_in0,
    input  logic [3:0]          M_in1,
    input  logic [3:0]          M_in0,
    input  logic                LD_time,
    input  logic                LD_alarm,
    input  logic [AW-1:0]       AL_SEL,
    input  logic [N_ALARMS-1:0] AL_EN,
    input  logic                STOP_al,
    input  logic                SNOOZE,
    output logic [N_ALARMS-1:0] Alarm,
    output logic                Alarm_any,
    output logic [1:0]          H_out1,
    output logic [3:0]          H_out0,
    output logic [3:0]          M_out1,
    output logic [3:0]          M_out0,
    output logic [3:0]          S_out1,
    output logic [3:0]          S_out0,
    output logic                tick,
    output logic                ld_err
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int RW = $clog2(RING_TIMEOUT + 1);
    localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
    localparam logic [RW-1:0] RT_LAST = RW'(RING_TIMEOUT - 1);
    localparam logic [SW-1:0] SN_LOAD = SW'(SNOOZE_MIN * 60);
    localparam logic [AW:0]   NA      = (AW + 1)'(N_ALARMS);

    typedef enum logic [1:0] {IDLE, RING, SNZ} st_e;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [21:0]         tm_q, tm_d, tm_inc;
    logic [13:0]         al_q [N_ALARMS];
    logic [13:0]         al_d [N_ALARMS];
    st_e                 st_q [N_ALARMS];
    st_e                 st_d [N_ALARMS];
    logic [RW-1:0]       rc_q [N_ALARMS];
    logic [RW-1:0]       rc_d [N_ALARMS];
    logic [SW-1:0]       sc_q [N_ALARMS];
    logic [SW-1:0]       sc_d [N_ALARMS];
    logic                upd_q, upd_d, snz_q, ld_err_q, ld_err_d;
    logic                in_ok, sel_ok, ld_t, ld_a, snz_rise;
    logic [N_ALARMS-1:0] trig, kill;
    logic [1:0]          h1;
    logic [3:0]          h0, m1, m0, s1, s0;
    logic                c_s0, c_s1, c_m0, c_m1, c_h;

    assign {h1, h0, m1, m0, s1, s0} = tm_q;
    assign {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} = tm_q;
    assign tick      = cnt_q == CW'(CLK_DIV - 1);
    assign ld_err    = ld_err_q;
    assign Alarm_any = |Alarm;

    // Ripple-carry chain of the BCD time counter.
    assign c_s0 = s0 == 4'd9;
    assign c_s1 = c_s0 && s1 == 4'd5;
    assign c_m0 = c_s1 && m0 == 4'd9;
    assign c_m1 = c_m0 && m1 == 4'd5;
    assign c_h  = c_m1 && h1 == 2'd2 && h0 == 4'd3;
    assign tm_inc = {c_m1 ? (c_h ? 2'd0 : h1 + {1'b0, h0 == 4'd9}) : h1,
                     c_m1 ? ((c_h || h0 == 4'd9) ? 4'd0 : h0 + 4'd1) : h0,
                     c_m0 ? (c_m1 ? 4'd0 : m1 + 4'd1) : m1,
                     c_s1 ? (c_m0 ? 4'd0 : m0 + 4'd1) : m0,
                     c_s0 ? (c_s1 ? 4'd0 : s1 + 4'd1) : s1,
                     c_s0 ? 4'd0 : s0 + 4'd1};

    assign in_ok  = H_in0 <= 4'd9 && M_in1 <= 4'd5 && M_in0 <= 4'd9 &&
                    (H_in1 < 2'd2 || (H_in1 == 2'd2 && H_in0 <= 4'd3));
    assign sel_ok = {1'b0, AL_SEL} < NA;
    assign ld_t   = LD_time && in_ok;
    assign ld_a   = LD_alarm && in_ok && sel_ok;
    assign kill   = {N_ALARMS{STOP_al}} | ~AL_EN;

    always_comb begin
        ld_err_d = (LD_time && !in_ok) || (LD_alarm && !(in_ok && sel_ok));
        cnt_d    = (ld_t || tick) ? '0 : cnt_q + 1'b1;
        tm_d     = ld_t ? {H_in1, H_in0, M_in1, M_in0, 8'h00} : tick ? tm_inc : tm_q;
        upd_d    = ld_t || tick;
        snz_rise = SNOOZE && !snz_q;
    end

    // Release (kill) outranks snooze, trigger and timeout; snooze outranks timeout.
    always_comb begin
        trig  = '0;
        Alarm = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            al_d[i]  = (ld_a && AL_SEL == AW'(i)) ? {H_in1, H_in0, M_in1, M_in0} : al_q[i];
            trig[i]  = upd_q && tm_q == {al_q[i], 8'h00} && AL_EN[i] && !STOP_al;
            Alarm[i] = st_q[i] == RING;
            st_d[i]  = st_q[i];
            rc_d[i]  = rc_q[i];
            sc_d[i]  = sc_q[i];
            if (st_q[i] == IDLE) begin
                if (trig[i]) begin
                    st_d[i] = RING;
                    rc_d[i] = '0;
                end
            end else if (kill[i]) begin
                st_d[i] = IDLE;
            end else if (st_q[i] == RING) begin
                if (snz_rise) begin
                    st_d[i] = SNZ;
                    sc_d[i] = SN_LOAD;
                end else if (trig[i]) begin
                    rc_d[i] = '0;
                end else if (tick) begin
                    st_d[i] = (rc_q[i] == RT_LAST) ? IDLE : RING;
                    rc_d[i] = rc_q[i] + 1'b1;
                end
            end else if (trig[i] || (tick && sc_q[i] == SW'(1))) begin
                st_d[i] = RING;
                rc_d[i] = '0;
            end else if (tick) begin
                sc_d[i] = sc_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            tm_q     <= '0;
            upd_q    <= 1'b0;
            snz_q    <= 1'b0;
            ld_err_q <= 1'b0;
            for (int i = 0; i < N_ALARMS; i++) begin
                al_q[i] <= '0;
                st_q[i] <= IDLE;
                rc_q[i] <= '0;
                sc_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            tm_q     <= tm_d;
            upd_q    <= upd_d;
            snz_q    <= SNOOZE;
            ld_err_q <= ld_err_d;
            for (int i = 0; i < N_ALARMS; i++) begin
                al_q[i] <= al_d[i];
                st_q[i] <= st_d[i];
                rc_q[i] <= rc_d[i];
                sc_q[i] <= sc_d[i];
            end
        end
    end
endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb_multi_alarm_clock: directed scoreboard bench for multi_alarm_clock
// with default parameters (CLK_DIV=10, 4 alarms, 5 min snooze, 60 s timeout).
module tb_multi_alarm_clock;
    logic       clk = 1'b0, reset = 1'b0;
    logic [1:0] H_in1 = '0;
    logic [3:0] H_in0 = '0, M_in1 = '0, M_in0 = '0;
    logic       LD_time = 1'b0, LD_alarm = 1'b0, STOP_al = 1'b0, SNOOZE = 1'b0;
    logic [1:0] AL_SEL = '0;
    logic [3:0] AL_EN = '0;
    logic [3:0] Alarm;
    logic       Alarm_any, tick, ld_err;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

    typedef struct {string tag; logic [23:0] v;} exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0, ntick = 0;

    multi_alarm_clock dut (
        .clk(clk), .reset(reset), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1),
        .M_in0(M_in0), .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_SEL(AL_SEL),
        .AL_EN(AL_EN), .STOP_al(STOP_al), .SNOOZE(SNOOZE), .Alarm(Alarm),
        .Alarm_any(Alarm_any), .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1),
        .M_out0(M_out0), .S_out1(S_out1), .S_out0(S_out0), .tick(tick), .ld_err(ld_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (tick) ntick++;

    function automatic logic [23:0] tm();
        return {2'b00, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [23:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic chk(input logic [23:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic set_hm(input logic [1:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        H_in1 = a; H_in0 = b; M_in1 = c; M_in0 = d;
    endtask

    task automatic ld_time(input logic [1:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        set_hm(a, b, c, d);
        LD_time = 1'b1;
        cyc(1);
        LD_time = 1'b0;
    endtask

    task automatic ld_alarm(input logic [1:0] sel, input logic [1:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        set_hm(a, b, c, d);
        AL_SEL = sel;
        LD_alarm = 1'b1;
        cyc(1);
        LD_alarm = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP_al = 1'b1;
        cyc(1);
        STOP_al = 1'b0;
    endtask

    initial begin
        int n, s0, bad;
        cyc(3);
        push("rst_time", 24'h000000); push("rst_alarm", 24'h0); push("rst_any", 24'h0);
        push("rst_tick", 24'h0); push("rst_lderr", 24'h0);
        chk(tm()); chk({20'b0, Alarm}); chk({23'b0, Alarm_any}); chk({23'b0, tick}); chk({23'b0, ld_err});
        reset = 1'b1;
        s0 = ntick;
        push("idle_time", 24'h000100); push("idle_ticks", 24'd60); push("idle_alarm", 24'h0);
        cyc(600);
        chk(tm()); chk(24'(ntick - s0)); chk({20'b0, Alarm});

        ld_time(2'd2, 4'd3, 4'd5, 4'd9);
        push("ld_2359", 24'h235900); push("wrap", 24'h000000);
        chk(tm());
        cyc(600);
        chk(tm());

        ld_time(2'd2, 4'd5, 4'd0, 4'd0);
        push("bad_ld_err", 24'h1); push("bad_ld_time", 24'h000000); push("bad_ld_err_clr", 24'h0);
        chk({23'b0, ld_err}); chk(tm());
        cyc(1);
        chk({23'b0, ld_err});

        n = 0;
        while (tick !== 1'b1 && n < 20) begin cyc(1); n++; end
        push("tick_seen", 24'h1);
        chk({23'b0, tick});
        ld_time(2'd1, 4'd2, 4'd3, 4'd4);
        push("ld_vs_tick", 24'h123400);
        chk(tm());

        ld_alarm(2'd0, 2'd1, 4'd0, 4'd2, 4'd0);
        AL_EN = 4'b0001;
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        push("pre_1959", 24'h101959); push("show_2000", 24'h102000); push("no_ring_yet", 24'h0);
        push("ring0", 24'h1); push("ring0_any", 24'h1);
        cyc(599); chk(tm());
        cyc(1); chk(tm()); chk({20'b0, Alarm});
        cyc(1); chk({20'b0, Alarm}); chk({23'b0, Alarm_any});
        pulse_stop();
        push("stop_drop", 24'h0); push("stop_any", 24'h0);
        chk({20'b0, Alarm}); chk({23'b0, Alarm_any});

        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        cyc(601);
        push("ring_auto", 24'h1); push("auto_ticks", 24'd60); push("auto_drop", 24'h0);
        chk({20'b0, Alarm});
        s0 = ntick; n = 0;
        while (Alarm[0] !== 1'b0 && n < 1000) begin cyc(1); n++; end
        chk(24'(ntick - s0)); chk({20'b0, Alarm});

        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        cyc(601);
        SNOOZE = 1'b1;
        cyc(1);
        SNOOZE = 1'b0;
        push("snz_drop", 24'h0); push("snz_ticks", 24'd300); push("re_ring", 24'h1);
        chk({20'b0, Alarm});
        s0 = ntick; n = 0;
        while (Alarm[0] !== 1'b1 && n < 4000) begin cyc(1); n++; end
        chk(24'(ntick - s0)); chk({20'b0, Alarm});
        pulse_stop();

        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        cyc(601);
        SNOOZE = 1'b1;
        cyc(1);
        SNOOZE = 1'b0;
        cyc(100);
        pulse_stop();
        push("snz_stop_no_ring", 24'h0);
        bad = 0;
        repeat (3200) begin cyc(1); if (Alarm !== 4'b0) bad++; end
        chk(24'(bad));

        ld_alarm(2'd1, 2'd0, 4'd7, 4'd0, 4'd0);
        ld_alarm(2'd2, 2'd0, 4'd7, 4'd0, 4'd0);
        ld_alarm(2'd3, 2'd0, 4'd7, 4'd0, 4'd0);
        AL_EN = 4'b0110;
        ld_time(2'd0, 4'd6, 4'd5, 4'd9);
        push("multi_ring", 24'h6); push("multi_any", 24'h1); push("en_clear", 24'h4);
        cyc(601);
        chk({20'b0, Alarm}); chk({23'b0, Alarm_any});
        AL_EN = 4'b0100;
        cyc(1);
        chk({20'b0, Alarm});
        pulse_stop();

        AL_EN = 4'b0001;
        ld_time(2'd1, 4'd0, 4'd1, 4'd9);
        cyc(601);
        SNOOZE = 1'b1;
        cyc(1);
        SNOOZE = 1'b0;
        cyc(50);
        reset = 1'b0;
        #1;
        push("arst_time", 24'h0); push("arst_alarm", 24'h0); push("arst_any", 24'h0);
        push("arst_lderr", 24'h0); push("post_rst_no_ring", 24'h0);
        chk(tm()); chk({20'b0, Alarm}); chk({23'b0, Alarm_any}); chk({23'b0, ld_err});
        cyc(3);
        reset = 1'b1;
        bad = 0;
        repeat (3100) begin cyc(1); if (Alarm !== 4'b0) bad++; end
        chk(24'(bad));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
